// File: rtl/switch_sweep_ctrl.sv
// switch_sweep_ctrl: walks an N-bit switch pattern through every value,
// holds each value for SETTLE cycles, and then samples the combinational
// result y into a 2**N-bit truth table and a count of ones.
//
// Optional feature macro: SWEEP_CHECK_EN
//   When defined, the block gains an 'expected' input and a 'mismatch'
//   output. 'mismatch' flags a finished truth table that differs from
//   'expected'.
//
// The captured truth table is presented on port 'truth_table'. The name
// 'table' is a reserved word in SystemVerilog, so it cannot be a port name.
//
// Handshake: start is a level request that is taken only in IDLE.
//   busy is high for the whole sweep (SETTLE/SAMPLE).
//   done pulses for exactly one cycle, in the cycle after the last sample edge.
//   abort cancels an active sweep on the next edge and beats start in IDLE.
//   Results stay stable while busy is low.
//   The FSM state is in state_q, which a bound checker can read.
module switch_sweep_ctrl #(
  parameter int N      = 3,
  parameter int SETTLE = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              y,
`ifdef SWEEP_CHECK_EN
  input  logic [2**N-1:0]   expected,
  output logic              mismatch,
`endif
  output logic [N-1:0]      switches,
  output logic              busy,
  output logic              done,
  output logic [2**N-1:0]   truth_table,
  output logic [N:0]        ones
);

  localparam int PATS = 2**N;
  localparam int CW   = 4;
  localparam logic [N-1:0]  LAST_PAT    = {N{1'b1}};
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_DONE
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic [CW-1:0]   cnt_q;
  logic            in_sweep;
  logic            sweep_start;
  logic            sweep_abort;
  logic            sample_fire;
  logic            last_pat;
  logic [PATS-1:0] table_upd;

  // In IDLE, abort has priority over start, so both high is no request.
  assign in_sweep    = (state_q == ST_SETTLE) || (state_q == ST_SAMPLE);
  assign sweep_start = (state_q == ST_IDLE) && start && !abort;
  assign sweep_abort = in_sweep && abort;
  assign sample_fire = (state_q == ST_SAMPLE) && !abort;
  assign last_pat    = (switches == LAST_PAT);

  // Next-state selection. An abort leaves the sweep before any sample lands.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start && !abort) state_d = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (abort)                     state_d = ST_IDLE;
        else if (cnt_q == SETTLE_LAST) state_d = ST_SAMPLE;
      end
      ST_SAMPLE: begin
        if (abort)         state_d = ST_IDLE;
        else if (last_pat) state_d = ST_DONE;
        else               state_d = ST_SETTLE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Build the table as it will look after this sample edge.
  // The final-table comparison uses it so it sees the last bit.
  always_comb begin
    table_upd           = truth_table;
    table_upd[switches] = y;
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Settle counter. It runs only while settling and is zero everywhere else,
  // so every pattern starts its hold time from zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                 cnt_q <= '0;
    else if (state_q == ST_SETTLE && !abort) cnt_q <= cnt_q + CW'(1);
    else                                     cnt_q <= '0;
  end

  // Switch pattern. It restarts at 0 on start or abort.
  // It advances only after a sample that was not the last one, so it never wraps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                        switches <= '0;
    else if (sweep_start)           switches <= '0;
    else if (sweep_abort)           switches <= '0;
    else if (sample_fire && !last_pat) switches <= switches + N'(1);
  end

  // Result capture. Results clear on an accepted start and change only on
  // sample edges, so they hold through IDLE and after an abort.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      truth_table <= '0;
      ones        <= '0;
    end else if (sweep_start) begin
      truth_table <= '0;
      ones        <= '0;
    end else if (sample_fire) begin
      truth_table <= table_upd;
      ones        <= ones + (N+1)'(y);
    end
  end

`ifdef SWEEP_CHECK_EN
  // Compare the finished table with the reference on the edge into DONE.
  // The flag holds until the next accepted start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                          mismatch <= 1'b0;
    else if (sweep_start)             mismatch <= 1'b0;
    else if (sample_fire && last_pat) mismatch <= (table_upd != expected);
  end
`endif

  // Status flags are decoded straight from the registered state.
  assign busy = in_sweep;
  assign done = (state_q == ST_DONE);

endmodule

// File: tb/tb_switch_sweep_ctrl.sv
// Testbench for switch_sweep_ctrl (N=3, SETTLE=2).
// The function under test is a truth table held by the bench. Its output is
// deliberately wrong until the switches have been stable long enough, so a
// sample taken too early reads a wrong bit.
// Optional feature macro: SWEEP_CHECK_EN (expected/mismatch ports).
module tb_switch_sweep_ctrl;

  localparam int N      = 3;
  localparam int SETTLE = 2;
  localparam int PATS   = 2**N;
  localparam int L      = PATS * (SETTLE + 1);
  localparam logic [PATS-1:0] MAJ_TBL = 8'b1110_1000;

  typedef struct packed {
    logic            was_done;
    logic [7:0]      lat;
    logic [N-1:0]    sw;
    logic [PATS-1:0] tbl;
    logic [N:0]      ones;
    logic            mism;
  } exp_t;
  localparam int W = $bits(exp_t);

  logic clk;
  logic rst;
  logic start;
  logic abort;
  logic y;
  logic [N-1:0]    switches;
  logic            busy;
  logic            done;
  logic [PATS-1:0] truth_table;
  logic [N:0]      ones;
`ifdef SWEEP_CHECK_EN
  logic [PATS-1:0] expected_tbl;
  logic            mismatch;
`endif

  logic [W-1:0]    exp_q[$];
  int              checks = 0;
  int              errors = 0;

  logic [PATS-1:0] func_tbl = '0;
  logic [N-1:0]    sw_prev = '0;
  int              stable = 100;

  logic [PATS-1:0] last_tbl = '0;
  logic [N:0]      last_ones = '0;

  switch_sweep_ctrl #(.N(N), .SETTLE(SETTLE)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .abort       (abort),
    .y           (y),
`ifdef SWEEP_CHECK_EN
    .expected    (expected_tbl),
    .mismatch    (mismatch),
`endif
    .switches    (switches),
    .busy        (busy),
    .done        (done),
    .truth_table (truth_table),
    .ones        (ones)
  );

  // Clock and watchdog.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Settling model of the function: y is inverted until switches have been
  // stable for SETTLE-1 observed edges.
  always @(posedge clk) begin
    if (switches != sw_prev) stable <= 0;
    else if (stable < 100)   stable <= stable + 1;
    sw_prev <= switches;
  end

  always_comb begin
    if (stable >= SETTLE - 1) y = func_tbl[switches];
    else                      y = ~func_tbl[switches];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference truth tables, derived from the definition of each function.
  function automatic logic [PATS-1:0] func_of(input int mode);
    logic [PATS-1:0] t;
    logic [N-1:0]    v;
    t = '0;
    for (int i = 0; i < PATS; i++) begin
      v = N'(i);
      case (mode)
        0:       t[i] = ($countones(v) > N / 2);
        1:       t[i] = ^v;
        2:       t[i] = 1'b1;
        3:       t[i] = 1'b0;
        default: t[i] = 1'($urandom_range(0, 1));
      endcase
    end
    return t;
  endfunction

  // Monitor: every falling edge of busy ends a sweep, whether by done, abort
  // or reset. Each end is compared with the next expected entry.
  int   cyc = 0;
  logic busy_prev = 1'b0;
  logic done_prev = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (done) check("done_one_cycle", 32'(done_prev), 32'd0);
    if (busy && !busy_prev) cyc = 1;
    else if (busy)          cyc = cyc + 1;
    if (busy_prev && !busy) begin
      if (exp_q.size() == 0) begin
        check("unexpected_sweep_end", 32'd1, 32'd0);
      end else begin
        e = exp_t'(exp_q.pop_front());
        check("end_done",    32'(done),        32'(e.was_done));
        check("end_latency", 32'(cyc),         32'(e.lat));
        check("end_switches",32'(switches),    32'(e.sw));
        check("end_table",   32'(truth_table), 32'(e.tbl));
        check("end_ones",    32'(ones),        32'(e.ones));
`ifdef SWEEP_CHECK_EN
        check("end_mismatch",32'(mismatch),    32'(e.mism));
`endif
      end
    end
    busy_prev = busy;
    done_prev = done;
  end

  task automatic wait_idle();
    for (int i = 0; i < 4 * L; i++) begin
      @(negedge clk);
      if (!busy) break;
    end
    check("idle_timeout", 32'(busy), 32'd0);
  endtask

  task automatic hold_check();
    repeat (3) @(posedge clk);
    #1;
    check("hold_busy",  32'(busy),        32'd0);
    check("hold_table", 32'(truth_table), 32'(last_tbl));
    check("hold_ones",  32'(ones),        32'(last_ones));
  endtask

  // Called at #1 after a rising edge. Start is accepted on the next edge (edge 0).
  // abort_at: 0 means none. 1..L aborts the sweep. L+1 falls in DONE and has no effect.
  // rst_at: nonzero asserts reset just after that edge.
  task automatic run_sweep(input int mode, input int abort_at, input int rst_at);
    exp_t e;
    logic [PATS-1:0] f;
    f = func_of(mode);
    func_tbl = f;
    e = '0;
    if (rst_at > 0) begin
      e.lat = 8'(rst_at);
    end else if (abort_at >= 1 && abort_at <= L) begin
      for (int i = 0; i < PATS; i++)
        if ((i + 1) * (SETTLE + 1) < abort_at) e.tbl[i] = f[i];
      e.lat  = 8'(abort_at);
      e.ones = (N+1)'($countones(e.tbl));
    end else begin
      e.was_done = 1'b1;
      e.lat      = 8'(L);
      e.sw       = {N{1'b1}};
      e.tbl      = f;
      e.ones     = (N+1)'($countones(f));
      e.mism     = (f != MAJ_TBL);
    end
    exp_q.push_back(W'(e));
    last_tbl  = e.tbl;
    last_ones = e.ones;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    if (abort_at >= 1) begin
      repeat (abort_at - 1) @(posedge clk);
      #1 abort = 1'b1;
      @(posedge clk);
      #1 abort = 1'b0;
    end else if (rst_at >= 1) begin
      repeat (rst_at) @(posedge clk);
      #1 rst = 1'b1;
      #1;
      check("rst_busy",     32'(busy),        32'd0);
      check("rst_done",     32'(done),        32'd0);
      check("rst_switches", 32'(switches),    32'd0);
      check("rst_table",    32'(truth_table), 32'd0);
      check("rst_ones",     32'(ones),        32'd0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
    end
    wait_idle();
    hold_check();
  endtask

  // Start held high across two sweeps. It must re-trigger only from IDLE.
  task automatic run_held(input int mode);
    exp_t e;
    logic [PATS-1:0] f;
    f = func_of(mode);
    func_tbl = f;
    e = '0;
    e.was_done = 1'b1;
    e.lat      = 8'(L);
    e.sw       = {N{1'b1}};
    e.tbl      = f;
    e.ones     = (N+1)'($countones(f));
    e.mism     = (f != MAJ_TBL);
    exp_q.push_back(W'(e));
    exp_q.push_back(W'(e));
    last_tbl  = e.tbl;
    last_ones = e.ones;
    start = 1'b1;
    repeat (L + 2) @(posedge clk);
    @(negedge clk);
    check("held_idle_gap_busy", 32'(busy), 32'd0);
    check("held_idle_gap_done", 32'(done), 32'd0);
    @(posedge clk);
    #1 start = 1'b0;
    check("held_retrigger", 32'(busy), 32'd1);
    wait_idle();
    hold_check();
  endtask

  // Stimulus sequence.
  initial begin
    int mode;
    int ab;
    rst   = 1'b1;
    start = 1'b0;
    abort = 1'b0;
`ifdef SWEEP_CHECK_EN
    expected_tbl = MAJ_TBL;
`endif
    #1;
    check("reset_busy",     32'(busy),        32'd0);
    check("reset_done",     32'(done),        32'd0);
    check("reset_switches", 32'(switches),    32'd0);
    check("reset_table",    32'(truth_table), 32'd0);
    check("reset_ones",     32'(ones),        32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    run_sweep(0, 0, 0);          // majority, start taken on first edge after reset
    run_sweep(1, 0, 0);          // xor
    run_sweep(0, 10, 0);         // abort at edge 10
    run_sweep(0, 0, 15);         // reset at edge 15
    run_sweep(0, 0, 0);          // full sweep right after reset release
    run_held(1);                 // start held high

    // Start and abort together in IDLE: no sweep, results unchanged.
    start = 1'b1;
    abort = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    abort = 1'b0;
    check("idle_abort_busy",  32'(busy),        32'd0);
    check("idle_abort_table", 32'(truth_table), 32'(last_tbl));

    run_sweep(2, L + 1, 0);      // constant 1, abort during DONE ignored
    run_sweep(3, 0, 0);          // constant 0
    run_sweep(1, L, 0);          // abort on the final sample edge
    run_sweep(1, 1, 0);          // abort on the first settle edge

    for (int k = 0; k < 12; k++) begin
      mode = $urandom_range(0, 4);
      ab   = ($urandom_range(0, 3) == 0) ? $urandom_range(1, L + 1) : 0;
      run_sweep(mode, ab, 0);
    end

    repeat (4) @(posedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/switch_sweep_ctrl.md
SWITCH_SWEEP_CTRL -- requirements
Module: switch_sweep_ctrl

Interface
REQ-001 Parameter: N, 3, width of the switch vector driven into the combinational function under test.
REQ-002 Parameter: SETTLE, 2, number of clock cycles each pattern is held before y is sampled; legal range 1..15.
REQ-003 Port: clk  input  1  single clock; all state changes on the rising edge.
REQ-004 Port: rst  input  1  asynchronous, active-high reset.
REQ-005 Port: start  input  1  request a full sweep; accepted only in IDLE.
REQ-006 Port: abort  input  1  synchronous cancel of a sweep in progress.
REQ-007 Port: y  input  1  output of the combinational function being swept.
REQ-008 Port: switches  output  N  pattern currently driven to the function.
REQ-009 Port: busy  output  1  high while a sweep is in progress (SETTLE or SAMPLE state).
REQ-010 Port: done  output  1  one-cycle pulse when a sweep completes.
REQ-011 Port: table  output  2**N  captured truth table; bit i = y sampled with switches == i.
REQ-012 Port: ones  output  N+1  number of patterns for which y sampled 1.

Function
REQ-013 The FSM SHALL have exactly four states: IDLE, SETTLE, SAMPLE, DONE.
REQ-014 IDLE with start=1 at an edge -> SETTLE; on that edge switches<=0, table<=0, ones<=0, settle counter<=0.
REQ-015 SETTLE SHALL last exactly SETTLE cycles (counter increments each edge, exits when counter == SETTLE-1) -> SAMPLE.
REQ-016 SAMPLE SHALL last exactly one cycle; on its edge table[switches]<=y and ones<=ones+y.
REQ-017 SAMPLE with switches == 2**N-1 -> DONE, switches unchanged; otherwise switches<=switches+1, counter<=0, -> SETTLE.
REQ-018 switches SHALL never wrap during a sweep; the increment past 2**N-1 never occurs.
REQ-019 DONE SHALL last one cycle with done=1, busy=0, then -> IDLE unconditionally.
REQ-020 busy SHALL be a decode of state (SETTLE or SAMPLE); done a decode of DONE; both glitch-free registered-state decodes.
REQ-021 Latency: done is high in the cycle 2**N*(SETTLE+1) edges after the start edge (24 for N=3, SETTLE=2).
REQ-022 start SHALL be ignored in SETTLE, SAMPLE and DONE; a start held high re-triggers only after returning to IDLE.
REQ-023 abort=1 in SETTLE or SAMPLE SHALL take priority over the sample: -> IDLE next edge, no table/ones update that edge, done not asserted, switches<=0.
REQ-024 abort in IDLE or DONE SHALL have no effect; start and abort both high in IDLE -> abort wins, stays IDLE.
REQ-025 table and ones SHALL hold their values in IDLE (after done or abort) until the next accepted start.
REQ-026 ones SHALL equal the popcount of table at every DONE cycle; max value 2**N, no overflow.

Reset
REQ-027 rst=1 SHALL immediately (asynchronously) force state IDLE, switches=0, busy=0, done=0, table=0, ones=0, counter=0.
REQ-028 Reset asserted mid-sweep SHALL discard all partial results; no done pulse follows deassertion.
REQ-029 After rst deasserts, the first start SHALL be accepted on the first rising edge.

Configuration
REQ-030 Macro SWEEP_CHECK_EN: when defined, adds port expected input 2**N and port mismatch output 1.
REQ-031 With SWEEP_CHECK_EN, on the edge entering DONE mismatch<=(table_final != expected), held until next accepted start (cleared to 0 then) or reset (0).
REQ-032 Without SWEEP_CHECK_EN, neither port exists and all other behaviour is identical.

Verification
REQ-033 N=3, SETTLE=2, y=majority(switches); pulse start -> done at edge 24, table=8'b1110_1000, ones=4.
REQ-034 y=XOR of switches; start -> table=8'b1001_0110, ones=4; start held high through sweep -> exactly one sweep per return to IDLE.
REQ-035 Majority sweep, abort at edge 10 after start -> IDLE, busy=0, no done, switches=0, table holds samples for patterns 0..2 only.
REQ-036 rst asserted at edge 15 of a sweep -> all outputs 0 immediately; new start after release -> full correct 24-cycle sweep.
REQ-037 SWEEP_CHECK_EN, expected=8'b1110_1000: majority -> mismatch=0; y forced 0 -> table=0, ones=0, mismatch=1.
REQ-038 SETTLE=1: start -> done at edge 16; y=1 constant -> table=8'hFF, ones=8.
